imem_fetch_resp: RTL and testbench

- Instruction-memory responder at the far end of the fetch interface: accepts word fetch requests issued from the program-counter address and returns 32-bit instruction words in order.
- Fixed, parameterised read latency; output buffer with ready/valid backpressure; flush on redirect (branch/jump).
- Contents are loaded through a side write port, by the testbench or the boot loader.

---
 rtl/mips_pkg.sv | 19 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/imem_fetch_resp.sv | 123 ++++++++++++
 tb/tb_imem_fetch_resp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch path.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // One fetch response as it travels through the latency pipe and output buffer.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic            err;
    } fetch_rsp_t;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is visible on dout
// whenever the FIFO is non-empty. There is no write-to-read bypass.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: accepts word fetches, reads a synchronous
// memory, delays the result through a fixed-latency pipe and returns words in
// order through a credit-protected output buffer. Flush drops everything
// except a request accepted in the flush cycle.
module imem_fetch_resp
    import mips_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int LATENCY     = 2,
    parameter  int BUF_DEPTH   = 4,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic [31:0]      rsp_addr,
    output logic             rsp_err,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [31:0]      ld_data
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = $clog2(LATENCY + BUF_DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    logic [LATENCY-1:0] pipe_valid;
    fetch_rsp_t         pipe_q [LATENCY];

    logic             accept;
    logic             req_oor;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;

    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_rsp_t       head;

    assign req_oor = ({2'b00, req_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));
    assign req_err = is_misaligned(req_addr) || req_oor;
    assign req_idx = req_addr[IDX_W+1:2];
    assign accept  = req_valid && req_ready;

    // Count occupied pipe stages; they hold buffer credit until they land.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_valid[i]);
        end
    end

    assign occupancy = inflight + OCC_W'(fifo_count);
    assign req_ready = !rst && (occupancy < OCC_W'(BUF_DEPTH));

    // Stage valids: flush kills the pipe but keeps a same-cycle request, which is the redirected path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1] && !flush;
            end
            pipe_valid[0] <= accept;
        end
    end

    // Memory load port, read-first synchronous read into stage 1, and data shift through the pipe.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (accept) begin
            pipe_q[0].addr <= req_addr;
            pipe_q[0].err  <= req_err;
            if (req_err) pipe_q[0].instr <= NOP_INSTR;
            else         pipe_q[0].instr <= mem[req_idx];
        end
        for (int i = LATENCY - 1; i > 0; i--) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign fifo_push = pipe_valid[LATENCY-1] && !flush;
    assign fifo_pop  = rsp_valid && rsp_ready;

    sync_fifo #(
        .WIDTH ($bits(fetch_rsp_t)),
        .DEPTH (BUF_DEPTH)
    ) u_rsp_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .din   (pipe_q[LATENCY-1]),
        .pop   (fifo_pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The credit scheme must never let a landing word find the buffer full.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(fifo_push && fifo_full && !fifo_pop));
    end

    assign rsp_valid = !fifo_empty;
    assign rsp_instr = rsp_valid ? head.instr : NOP_INSTR;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp with default parameters.
module tb_imem_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_mem [4];
    logic [31:0] last_word;

    imem_fetch_resp dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_mem[0] = 32'h2001_0005;
        exp_mem[1] = 32'h2002_000A;
        exp_mem[2] = 32'h0022_1820;
        exp_mem[3] = 32'hAC03_0000;
        last_word  = 32'h1234_5678;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ld_en   = 1'b1;
            ld_addr = (i < 4) ? 10'(i) : 10'd1023;
            ld_data = (i < 4) ? exp_mem[i] : last_word;
            tick();
        end
        ld_en = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        tests++; if (rsp_instr !== 32'h0) begin fails++; $display("FAIL reset_rsp_instr got %08h want 00000000", rsp_instr); end
        tests++; if (rsp_addr !== 32'h0) begin fails++; $display("FAIL reset_rsp_addr got %08h want 00000000", rsp_addr); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %0b want 0", rsp_err); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
        rst = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_req_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_fetch();
        rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 4);
            req_addr  = 32'(4 * c);
            if (c < 4) begin
                tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL fetch_req_ready c=%0d got %0b want 1", c, req_ready); end
            end
            tick();
            tests++;
            if (rsp_valid !== ((c >= 2) && (c <= 5))) begin
                fails++; $display("FAIL fetch_rsp_valid c=%0d got %0b want %0b", c, rsp_valid, (c >= 2) && (c <= 5));
            end else if (rsp_valid) begin
                if (rsp_addr !== 32'(4 * (c - 2)) || rsp_instr !== exp_mem[c-2] || rsp_err !== 1'b0) begin
                    fails++; $display("FAIL fetch_rsp c=%0d got addr=%08h instr=%08h err=%0b want addr=%08h instr=%08h err=0",
                                      c, rsp_addr, rsp_instr, rsp_err, 32'(4 * (c - 2)), exp_mem[c-2]);
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_addr = 32'(4 * (accepted % 4));
            tests++; if (req_ready !== (accepted < 4)) begin fails++; $display("FAIL bp_req_ready c=%0d got %0b want %0b", c, req_ready, accepted < 4); end
            if (req_ready === 1'b1) accepted++;
            tick();
        end
        req_valid = 1'b0;
        tests++; if (accepted != 4) begin fails++; $display("FAIL bp_accept_count got %0d want 4", accepted); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_full_req_ready got %0b want 0", req_ready); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_addr !== 32'(4 * k) || rsp_instr !== exp_mem[k]) begin
                fails++; $display("FAIL bp_drain k=%0d got valid=%0b addr=%08h instr=%08h want valid=1 addr=%08h instr=%08h",
                                  k, rsp_valid, rsp_addr, rsp_instr, 32'(4 * k), exp_mem[k]);
            end
            tick();
            if (k == 0) begin
                tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got %0b want 1", req_ready); end
            end
        end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drained_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        errs  [4];
        logic [31:0] instrs[4];
        addrs[0] = 32'h0000_0006; errs[0] = 1'b1; instrs[0] = 32'h0;
        addrs[1] = 32'h0000_1000; errs[1] = 1'b1; instrs[1] = 32'h0;
        addrs[2] = 32'h0000_0002; errs[2] = 1'b1; instrs[2] = 32'h0;
        addrs[3] = 32'h0000_0FFC; errs[3] = 1'b0; instrs[3] = last_word;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = addrs[k];
            tick();
            req_valid = 1'b0;
            tick();
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_err !== errs[k] || rsp_instr !== instrs[k] || rsp_addr !== addrs[k]) begin
                fails++; $display("FAIL err_rsp k=%0d got valid=%0b err=%0b instr=%08h addr=%08h want valid=1 err=%0b instr=%08h addr=%08h",
                                  k, rsp_valid, rsp_err, rsp_instr, rsp_addr, errs[k], instrs[k], addrs[k]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0; tick();
        req_addr = 32'h4; tick();
        req_valid = 1'b0; tick();
        req_valid = 1'b1; req_addr = 32'hC; tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h0) begin fails++; $display("FAIL flush_setup got valid=%0b addr=%08h want valid=1 addr=00000000", rsp_valid, rsp_addr); end
        flush = 1'b1; req_addr = 32'h8;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL flush_req_ready got %0b want 1", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_valid_next got %0b want 0", rsp_valid); end
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_valid_lat1 got %0b want 0", rsp_valid); end
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'h8 || rsp_instr !== 32'h0022_1820) begin
            fails++; $display("FAIL flush_redirect got valid=%0b addr=%08h instr=%08h want valid=1 addr=00000008 instr=00221820", rsp_valid, rsp_addr, rsp_instr);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_stale k=%0d got valid=%0b addr=%08h want valid=0", k, rsp_valid, rsp_addr); end
        end
    endtask

    task automatic test_collision();
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        ld_en = 1'b0; req_valid = 1'b0;
        tick();
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_instr !== exp_mem[1]) begin fails++; $display("FAIL collision_old got valid=%0b instr=%08h want valid=1 instr=%08h", rsp_valid, rsp_instr, exp_mem[1]); end
        exp_mem[1] = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_instr !== exp_mem[1]) begin fails++; $display("FAIL collision_new got valid=%0b instr=%08h want valid=1 instr=%08h", rsp_valid, rsp_instr, exp_mem[1]); end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req_addr = 32'(4 * c);
            tick();
        end
        req_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rstmid_setup got valid=%0b want 1", rsp_valid); end
        rst = 1'b1;
        tick();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rstmid_state got valid=%0b ready=%0b want valid=0 ready=0", rsp_valid, req_ready); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale k=%0d got valid=%0b addr=%08h want valid=0", k, rsp_valid, rsp_addr); end
        end
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; req_addr = (k == 0) ? 32'hC : 32'h4;
            tick();
            req_valid = 1'b0;
            tick();
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_instr !== exp_mem[(k == 0) ? 3 : 1]) begin
                fails++; $display("FAIL rstmid_retain k=%0d got valid=%0b instr=%08h want valid=1 instr=%08h", k, rsp_valid, rsp_instr, exp_mem[(k == 0) ? 3 : 1]);
            end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch();
        test_backpressure();
        test_errors();
        test_flush();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
